// File: rtl/c2m_txn_driver.sv
// c2m_txn_driver: buffers host commands in a FIFO, issues them one at a time on
// the C2M send_command handshake, and (optionally) scoreboards returned reads
// against a shadow copy of written lines.
// Optional feature macro: C2M_DRV_SCOREBOARD_EN builds the shadow store, tag
// table, outstanding count and match/mismatch/unchecked statistics. When it is
// undefined only the FIFO and issue FSM exist and the scoreboard outputs read 0.
module c2m_txn_driver #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 512,
    parameter int TAG_W     = 3,
    parameter int CMD_DEPTH = 4,
    parameter int SHADOW_AW = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              sc_valid,
    output logic              sc_operation,
    output logic [ADDR_W-1:0] sc_address,
    output logic [DATA_W-1:0] sc_data,
    input  logic              sc_full,
    input  logic              sc_ack,
    input  logic [TAG_W-1:0]  sc_tag,
    input  logic              rd_ack,
    input  logic [TAG_W-1:0]  rd_tag,
    input  logic [DATA_W-1:0] rd_data,
    output logic [TAG_W:0]    outstanding,
    output logic [15:0]       match_count,
    output logic [15:0]       mismatch_count,
    output logic [15:0]       unchecked_count,
    output logic              timeout_err,
    output logic              busy
);

    localparam int PTR_W  = $clog2(CMD_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(CMD_DEPTH);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // ---------------- command FIFO ----------------
    logic              fifo_op_q   [CMD_DEPTH];
    logic [ADDR_W-1:0] fifo_addr_q [CMD_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [CMD_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              cmd_ready_q;
    logic              push_s, pop_s;

    // ---------------- issue FSM ----------------
    state_t            state_q, state_d;
    logic              issue_ok_q, issue_ok_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              sc_valid_q, sc_valid_d;
    logic              sc_op_q, sc_op_d;
    logic [ADDR_W-1:0] sc_addr_q, sc_addr_d;
    logic [DATA_W-1:0] sc_data_q, sc_data_d;
    logic              timeout_q, timeout_d;

    assign push_s = cmd_valid && cmd_ready_q;
    assign pop_s  = (state_q == ST_ISSUE) && sc_ack;

    // Next FIFO occupancy from this cycle's push/pop pair.
    always_comb begin
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // FIFO payload storage; contents are don't-care until written.
    always_ff @(posedge clock) begin
        if (push_s) begin
            fifo_op_q[wr_ptr_q]   <= cmd_op;
            fifo_addr_q[wr_ptr_q] <= cmd_addr;
            fifo_data_q[wr_ptr_q] <= cmd_data;
        end
    end

    // FIFO pointers, occupancy and the registered ready flag (low in reset).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            count_q     <= {CNT_W{1'b0}};
            cmd_ready_q <= 1'b0;
        end else begin
            if (push_s) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop_s)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            count_q     <= count_d;
            cmd_ready_q <= (count_d != CNT_FULL);
        end
    end

    // Issue FSM next state and presented-command registers.
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        sc_valid_d = sc_valid_q;
        sc_op_d    = sc_op_q;
        sc_addr_d  = sc_addr_q;
        sc_data_d  = sc_data_q;
        timeout_d  = timeout_q;
        // Eligibility is re-earned by a full cycle in IDLE, so a retried
        // command returns two cycles after being withdrawn.
        issue_ok_d = (state_q == ST_IDLE) && (count_q != {CNT_W{1'b0}});
        case (state_q)
            ST_IDLE: begin
                if (issue_ok_q && !sc_full) begin
                    state_d    = ST_ISSUE;
                    wait_d     = {WAIT_W{1'b0}};
                    sc_valid_d = 1'b1;
                    sc_op_d    = fifo_op_q[rd_ptr_q];
                    sc_addr_d  = fifo_addr_q[rd_ptr_q];
                    sc_data_d  = fifo_data_q[rd_ptr_q];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (sc_ack) begin
                    state_d    = ST_GAP;
                    sc_valid_d = 1'b0;
                end else if (sc_full) begin
                    state_d    = ST_IDLE;
                    sc_valid_d = 1'b0;
                end else if (wait_q == WAIT_LAST) begin
                    state_d    = ST_IDLE;
                    sc_valid_d = 1'b0;
                    timeout_d  = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_ONE;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d    = ST_IDLE;
                sc_valid_d = 1'b0;
            end
        endcase
    end

    // Issue FSM state and registered send_command outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            issue_ok_q <= 1'b0;
            wait_q     <= {WAIT_W{1'b0}};
            sc_valid_q <= 1'b0;
            sc_op_q    <= 1'b0;
            sc_addr_q  <= {ADDR_W{1'b0}};
            sc_data_q  <= {DATA_W{1'b0}};
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            issue_ok_q <= issue_ok_d;
            wait_q     <= wait_d;
            sc_valid_q <= sc_valid_d;
            sc_op_q    <= sc_op_d;
            sc_addr_q  <= sc_addr_d;
            sc_data_q  <= sc_data_d;
            timeout_q  <= timeout_d;
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign sc_valid     = sc_valid_q;
    assign sc_operation = sc_op_q;
    assign sc_address   = sc_addr_q;
    assign sc_data      = sc_data_q;
    assign timeout_err  = timeout_q;

`ifdef C2M_DRV_SCOREBOARD_EN
    localparam int NTAG  = 1 << TAG_W;
    localparam int NLINE = 1 << SHADOW_AW;
    localparam logic [TAG_W:0] OUT_ONE = (TAG_W + 1)'(1);

    // Saturating 16-bit statistics increment.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [DATA_W-1:0] shadow_q  [NLINE];
    logic [DATA_W-1:0] tag_exp_q [NTAG];
    logic [NLINE-1:0]  shadow_v_q;
    logic [NTAG-1:0]   tag_pend_q;
    logic [NTAG-1:0]   tag_known_q;
    logic [TAG_W:0]    outstanding_q;
    logic [15:0]       match_q, mismatch_q, unchecked_q;
    logic [SHADOW_AW-1:0] idx_s;
    logic acc_wr_s, acc_rd_s, ret_s, unk_s, hit_s, inc_s, dec_s;

    assign idx_s    = sc_addr_q[SHADOW_AW+5:6];
    assign acc_wr_s = pop_s && sc_op_q;
    assign acc_rd_s = pop_s && !sc_op_q;
    assign ret_s    = rd_ack && tag_pend_q[rd_tag];
    assign unk_s    = rd_ack && !tag_pend_q[rd_tag];
    assign hit_s    = (tag_exp_q[rd_tag] == rd_data);
    assign dec_s    = ret_s;
    // A new read on a tag that stays pending only counts when that same
    // tag is being retired in this cycle.
    assign inc_s    = acc_rd_s && (!tag_pend_q[sc_tag] || (ret_s && (rd_tag == sc_tag)));

    // Shadow line data and expected read data; validity is tracked separately.
    always_ff @(posedge clock) begin
        if (acc_wr_s) shadow_q[idx_s] <= sc_data_q;
        if (acc_rd_s) tag_exp_q[sc_tag] <= shadow_q[idx_s];
    end

    // Tag table flags, shadow validity, outstanding count and statistics.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shadow_v_q    <= {NLINE{1'b0}};
            tag_pend_q    <= {NTAG{1'b0}};
            tag_known_q   <= {NTAG{1'b0}};
            outstanding_q <= {(TAG_W + 1){1'b0}};
            match_q       <= 16'h0000;
            mismatch_q    <= 16'h0000;
            unchecked_q   <= 16'h0000;
        end else begin
            if (acc_wr_s) shadow_v_q[idx_s] <= 1'b1;
            // Retire first so a same-tag allocation below overrides it.
            if (ret_s) begin
                tag_pend_q[rd_tag] <= 1'b0;
                if (tag_known_q[rd_tag]) begin
                    if (hit_s) match_q    <= sat_inc16(match_q);
                    else       mismatch_q <= sat_inc16(mismatch_q);
                end else begin
                    unchecked_q <= sat_inc16(unchecked_q);
                end
            end else if (unk_s) begin
                unchecked_q <= sat_inc16(unchecked_q);
            end
            if (acc_rd_s) begin
                tag_pend_q[sc_tag]  <= 1'b1;
                tag_known_q[sc_tag] <= shadow_v_q[idx_s];
            end
            case ({inc_s, dec_s})
                2'b10:   outstanding_q <= outstanding_q + OUT_ONE;
                2'b01:   outstanding_q <= outstanding_q - OUT_ONE;
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

    assign outstanding     = outstanding_q;
    assign match_count     = match_q;
    assign mismatch_count  = mismatch_q;
    assign unchecked_count = unchecked_q;
`else
    logic unused_sb_s;
    assign unused_sb_s     = ^{rd_ack, rd_tag, rd_data, sc_tag};
    assign outstanding     = {(TAG_W + 1){1'b0}};
    assign match_count     = 16'h0000;
    assign mismatch_count  = 16'h0000;
    assign unchecked_count = 16'h0000;
`endif

    assign busy = (count_q != {CNT_W{1'b0}}) || (state_q != ST_IDLE) ||
                  (outstanding != {(TAG_W + 1){1'b0}});

endmodule

// File: tb/tb_c2m_txn_driver.sv
// Directed self-checking bench for c2m_txn_driver (TIMEOUT=8). Scoreboard
// expectations follow C2M_DRV_SCOREBOARD_EN so the bench suits either build.
module tb_c2m_txn_driver;

`ifdef C2M_DRV_SCOREBOARD_EN
    localparam int SB = 1;
`else
    localparam int SB = 0;
`endif

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         cmd_valid = 1'b0, cmd_ready, cmd_op = 1'b0;
    logic [31:0]  cmd_addr = 32'h0;
    logic [511:0] cmd_data = 512'h0;
    logic         sc_valid, sc_operation;
    logic [31:0]  sc_address;
    logic [511:0] sc_data;
    logic         sc_full = 1'b0, sc_ack = 1'b0;
    logic [2:0]   sc_tag = 3'd0;
    logic         rd_ack = 1'b0;
    logic [2:0]   rd_tag = 3'd0;
    logic [511:0] rd_data = 512'h0;
    logic [3:0]   outstanding;
    logic [15:0]  match_count, mismatch_count, unchecked_count;
    logic         timeout_err, busy;

    int n_vec = 0;
    int n_err = 0;

    logic [511:0] pat40, pat200, ones;

    c2m_txn_driver #(
        .ADDR_W(32), .DATA_W(512), .TAG_W(3), .CMD_DEPTH(4), .SHADOW_AW(4), .TIMEOUT(8)
    ) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .sc_valid(sc_valid), .sc_operation(sc_operation), .sc_address(sc_address),
        .sc_data(sc_data), .sc_full(sc_full), .sc_ack(sc_ack), .sc_tag(sc_tag),
        .rd_ack(rd_ack), .rd_tag(rd_tag), .rd_data(rd_data),
        .outstanding(outstanding), .match_count(match_count),
        .mismatch_count(mismatch_count), .unchecked_count(unchecked_count),
        .timeout_err(timeout_err), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic op, input logic [31:0] addr, input logic [511:0] data);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic do_ack(input logic [2:0] tag);
        sc_ack = 1'b1; sc_tag = tag;
        tick();
        sc_ack = 1'b0;
    endtask

    task automatic retire(input logic [2:0] tag, input logic [511:0] data);
        rd_ack = 1'b1; rd_tag = tag; rd_data = data;
        tick();
        rd_ack = 1'b0;
    endtask

    task automatic wait_valid(output int n, output bit ok);
        n = 0;
        while (sc_valid !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        ok = (sc_valid === 1'b1);
    endtask

    task automatic test_reset();
        #2;
        n_vec++; if (sc_valid !== 1'b0) begin n_err++; $display("FAIL rst_sc_valid: got %0b want 0", sc_valid); end
        n_vec++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL rst_cmd_ready: got %0b want 0", cmd_ready); end
        n_vec++; if ({busy, timeout_err, outstanding} !== 6'd0) begin n_err++; $display("FAIL rst_status: got %0h want 0", {busy, timeout_err, outstanding}); end
        n_vec++; if ({match_count, mismatch_count, unchecked_count} !== 48'd0) begin n_err++; $display("FAIL rst_counts: got %0h want 0", {match_count, mismatch_count, unchecked_count}); end
        #10 reset = 1'b1;
        n_vec++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready_hold: got %0b want 0", cmd_ready); end
        tick();
        n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready_rise: got %0b want 1", cmd_ready); end
    endtask

    task automatic test_write_read_match();
        int n; bit ok;
        push(1'b1, 32'h40, pat40);
        n_vec++; if (sc_valid !== 1'b0) begin n_err++; $display("FAIL lat_n1: got %0b want 0", sc_valid); end
        push(1'b0, 32'h40, 512'h0);
        n_vec++; if (sc_valid !== 1'b0) begin n_err++; $display("FAIL lat_n1b: got %0b want 0", sc_valid); end
        tick();
        n_vec++; if (sc_valid !== 1'b1) begin n_err++; $display("FAIL lat_n2: got %0b want 1", sc_valid); end
        n_vec++; if ({sc_operation, sc_address} !== {1'b1, 32'h40}) begin n_err++; $display("FAIL wr_cmd: got %0h want 100000040", {sc_operation, sc_address}); end
        n_vec++; if (sc_data !== pat40) begin n_err++; $display("FAIL wr_data: got %0h want %0h", sc_data[31:0], pat40[31:0]); end
        do_ack(3'd0);
        n_vec++; if (sc_valid !== 1'b0) begin n_err++; $display("FAIL ack_drop: got %0b want 0", sc_valid); end
        wait_valid(n, ok);
        n_vec++; if (!ok || n != 3) begin n_err++; $display("FAIL ack_gap: got %0d cycles want 3", n); end
        n_vec++; if ({sc_operation, sc_address} !== {1'b0, 32'h40}) begin n_err++; $display("FAIL rd_cmd: got %0h want 40", {sc_operation, sc_address}); end
        do_ack(3'd1);
        n_vec++; if (outstanding !== 4'(SB)) begin n_err++; $display("FAIL out_one: got %0d want %0d", outstanding, SB); end
        retire(3'd1, pat40);
        n_vec++; if (match_count !== 16'(SB)) begin n_err++; $display("FAIL match1: got %0d want %0d", match_count, SB); end
        n_vec++; if (outstanding !== 4'd0) begin n_err++; $display("FAIL out_zero: got %0d want 0", outstanding); end
        tick();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %0b want 0", busy); end
    endtask

    task automatic test_mismatch_noshadow();
        int n; bit ok;
        push(1'b0, 32'h40, 512'h0);
        wait_valid(n, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL mm_issue: got no sc_valid want 1"); end
        do_ack(3'd2);
        retire(3'd2, ones);
        n_vec++; if (mismatch_count !== 16'(SB)) begin n_err++; $display("FAIL mismatch1: got %0d want %0d", mismatch_count, SB); end
        push(1'b0, 32'h80, 512'h0);
        wait_valid(n, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL ns_issue: got no sc_valid want 1"); end
        do_ack(3'd3);
        retire(3'd3, 512'h0);
        n_vec++; if (unchecked_count !== 16'(SB)) begin n_err++; $display("FAIL unchk1: got %0d want %0d", unchecked_count, SB); end
        retire(3'd5, 512'h0);
        n_vec++; if (unchecked_count !== 16'(2 * SB)) begin n_err++; $display("FAIL unchk_unknown: got %0d want %0d", unchecked_count, 2 * SB); end
        n_vec++; if (outstanding !== 4'd0) begin n_err++; $display("FAIL unk_out: got %0d want 0", outstanding); end
    endtask

    task automatic test_backpressure();
        int n; bit ok; bit seen;
        sc_full = 1'b1;
        for (int i = 0; i < 4; i++) push(1'b0, 32'h100 + 32'(i) * 32'h40, 512'h0);
        n_vec++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready: got %0b want 0", cmd_ready); end
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin tick(); if (sc_valid !== 1'b0) seen = 1'b1; end
        n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL bp_valid: got 1 want 0"); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL bp_busy: got %0b want 1", busy); end
        sc_full = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_valid(n, ok);
            n_vec++; if (!ok || (i > 0 && n != 3)) begin n_err++; $display("FAIL bp_gap%0d: got %0d cycles want 3", i, n); end
            n_vec++; if (sc_address !== 32'h100 + 32'(i) * 32'h40) begin n_err++; $display("FAIL bp_order%0d: got %0h want %0h", i, sc_address, 32'h100 + 32'(i) * 32'h40); end
            do_ack(3'(4 + i));
            if (i == 0) begin
                n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_back: got %0b want 1", cmd_ready); end
            end
        end
        n_vec++; if (outstanding !== 4'(4 * SB)) begin n_err++; $display("FAIL bp_out: got %0d want %0d", outstanding, 4 * SB); end
        rd_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin rd_tag = 3'(4 + k); tick(); end
        rd_ack = 1'b0;
        n_vec++; if (unchecked_count !== 16'(6 * SB)) begin n_err++; $display("FAIL bp_unchk: got %0d want %0d", unchecked_count, 6 * SB); end
        n_vec++; if (outstanding !== 4'd0) begin n_err++; $display("FAIL bp_out0: got %0d want 0", outstanding); end
    endtask

    task automatic test_timeout();
        int n; bit ok;
        n_vec++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL to_pre: got %0b want 0", timeout_err); end
        push(1'b1, 32'h200, pat200);
        wait_valid(n, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL to_issue: got no sc_valid want 1"); end
        n = 0;
        while (sc_valid === 1'b1 && n < 50) begin tick(); n++; end
        n_vec++; if (n != 8) begin n_err++; $display("FAIL to_len: got %0d cycles want 8", n); end
        n_vec++; if (timeout_err !== 1'b1) begin n_err++; $display("FAIL to_flag: got %0b want 1", timeout_err); end
        n = 0;
        while (sc_valid !== 1'b1 && n < 50) begin tick(); n++; end
        n_vec++; if (n != 2) begin n_err++; $display("FAIL to_retry: got %0d cycles want 2", n); end
        n_vec++; if ({sc_operation, sc_address} !== {1'b1, 32'h200}) begin n_err++; $display("FAIL to_same: got %0h want 100000200", {sc_operation, sc_address}); end
        do_ack(3'd0);
    endtask

    task automatic test_collision();
        int n; bit ok;
        push(1'b0, 32'h200, 512'h0);
        wait_valid(n, ok);
        do_ack(3'd2);
        n_vec++; if (!ok || outstanding !== 4'(SB)) begin n_err++; $display("FAIL col_setup: got %0d want %0d", outstanding, SB); end
        push(1'b0, 32'h40, 512'h0);
        wait_valid(n, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL col_issue: got no sc_valid want 1"); end
        sc_ack = 1'b1; sc_tag = 3'd2; rd_ack = 1'b1; rd_tag = 3'd2; rd_data = pat200;
        tick();
        sc_ack = 1'b0; rd_ack = 1'b0;
        n_vec++; if (match_count !== 16'(2 * SB)) begin n_err++; $display("FAIL col_match: got %0d want %0d", match_count, 2 * SB); end
        n_vec++; if (outstanding !== 4'(SB)) begin n_err++; $display("FAIL col_out: got %0d want %0d", outstanding, SB); end
        retire(3'd2, pat40);
        n_vec++; if (match_count !== 16'(3 * SB)) begin n_err++; $display("FAIL col_newent: got %0d want %0d", match_count, 3 * SB); end
        n_vec++; if ({outstanding, mismatch_count} !== {4'd0, 16'(SB)}) begin n_err++; $display("FAIL col_final: got %0h want %0h", {outstanding, mismatch_count}, {4'd0, 16'(SB)}); end
    endtask

    task automatic test_reset_mid_issue();
        int n; bit ok;
        push(1'b0, 32'h80, 512'h0);
        wait_valid(n, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL mid_pre: got no sc_valid want 1"); end
        #2 reset = 1'b0;
        #1;
        n_vec++; if ({sc_valid, cmd_ready, busy, timeout_err, outstanding} !== 8'd0) begin n_err++; $display("FAIL mid_async: got %0h want 0", {sc_valid, cmd_ready, busy, timeout_err, outstanding}); end
        n_vec++; if ({sc_operation, sc_address, match_count, mismatch_count, unchecked_count} !== 81'd0) begin n_err++; $display("FAIL mid_async2: got %0h want 0", {sc_operation, sc_address}); end
        #3 reset = 1'b1;
        tick();
        n_vec++; if ({cmd_ready, busy, sc_valid} !== 3'b100) begin n_err++; $display("FAIL mid_after: got %0b want 100", {cmd_ready, busy, sc_valid}); end
    endtask

    initial begin
        pat40  = {16{32'h0000_0040}};
        pat200 = {16{32'hA5A5_0200}};
        ones   = {16{32'hFFFF_FFFF}};
        test_reset();
        test_write_read_match();
        test_mismatch_noshadow();
        test_backpressure();
        test_timeout();
        test_collision();
        test_reset_mid_issue();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
